// File: rtl/alu_mdu_if.sv
// Request/response bundle between the EX-stage control unit (master) and alu_mdu (slave).
// Carries the op handshake, operands, registered result and the HI/LO view.
interface alu_mdu_if #(
    parameter int WIDTH = 32,
    parameter int SHW   = 5
);
    logic             op_valid;
    logic             op_ready;
    logic [4:0]       aluop;
    logic [WIDTH-1:0] src_a;
    logic [WIDTH-1:0] src_b;
    logic [SHW-1:0]   shamt;
    logic             res_valid;
    logic [WIDTH-1:0] result;
    logic             zero;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             busy;

    modport master (
        output op_valid, aluop, src_a, src_b, shamt,
        input  op_ready, res_valid, result, zero, hi, lo, busy
    );

    modport slave (
        input  op_valid, aluop, src_a, src_b, shamt,
        output op_ready, res_valid, result, zero, hi, lo, busy
    );
endinterface

// File: rtl/alu_mdu.sv
// Registered ALU with an iterative multiply/divide unit and HI/LO registers.
// Optional macro ALU_MDU_EARLY_OUT_EN lets MULT/MULTU finish once the multiplier runs out of set bits.
module alu_mdu #(
    parameter int WIDTH = 32,
    parameter int SHW   = 5
) (
    input  logic     clk,
    input  logic     rst_n,
    alu_mdu_if.slave bus
);
    localparam logic [4:0] OP_ADD   = 5'b00000;
    localparam logic [4:0] OP_SUB   = 5'b00001;
    localparam logic [4:0] OP_SLT   = 5'b00010;
    localparam logic [4:0] OP_AND   = 5'b00011;
    localparam logic [4:0] OP_NOR   = 5'b00100;
    localparam logic [4:0] OP_OR    = 5'b00101;
    localparam logic [4:0] OP_XOR   = 5'b00110;
    localparam logic [4:0] OP_SLL   = 5'b00111;
    localparam logic [4:0] OP_SRL   = 5'b01000;
    localparam logic [4:0] OP_SLTU  = 5'b01001;
    localparam logic [4:0] OP_SLLV  = 5'b01100;
    localparam logic [4:0] OP_SRA   = 5'b01101;
    localparam logic [4:0] OP_SRAV  = 5'b01110;
    localparam logic [4:0] OP_SRLV  = 5'b01111;
    localparam logic [4:0] OP_LUI   = 5'b10000;
    localparam logic [4:0] OP_MULT  = 5'b10001;
    localparam logic [4:0] OP_MULTU = 5'b10010;
    localparam logic [4:0] OP_DIV   = 5'b10011;
    localparam logic [4:0] OP_DIVU  = 5'b10100;
    localparam logic [4:0] OP_MFHI  = 5'b10101;
    localparam logic [4:0] OP_MFLO  = 5'b10110;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ITER = 2'd1,
        FIX  = 2'd2
    } state_t;

    state_t             state_reg, state_next;
    logic [SHW-1:0]     cnt_reg, cnt_next;
    logic [2*WIDTH-1:0] acc_reg, acc_next;
    logic [2*WIDTH-1:0] mcand_reg, mcand_next;
    logic [WIDTH-1:0]   opb_reg, opb_next;
    logic               is_div_reg, is_div_next;
    logic               neg_res_reg, neg_res_next;
    logic               neg_rem_reg, neg_rem_next;
    logic               div0_reg, div0_next;
    logic [WIDTH-1:0]   result_reg, result_next;
    logic               zero_reg, zero_next;
    logic [WIDTH-1:0]   hi_reg, hi_next;
    logic [WIDTH-1:0]   lo_reg, lo_next;
    logic               res_valid_reg, res_valid_next;

    logic               is_mc_op, is_div_op, is_signed_op;
    logic               a_neg, b_neg;
    logic [WIDTH-1:0]   a_mag, b_mag;
    logic [WIDTH-1:0]   alu_out;
    logic [2*WIDTH-1:0] pp_gated, mul_step, div_step;
    logic [WIDTH:0]     rem_shift, rem_diff;
    logic               q_bit;
    logic               early_accept, early_iter;
    logic [WIDTH-1:0]   quo_mag, rem_mag;

    assign is_div_op    = (bus.aluop == OP_DIV) || (bus.aluop == OP_DIVU);
    assign is_mc_op     = is_div_op || (bus.aluop == OP_MULT) || (bus.aluop == OP_MULTU);
    assign is_signed_op = (bus.aluop == OP_MULT) || (bus.aluop == OP_DIV);
    assign a_neg        = is_signed_op & bus.src_a[WIDTH-1];
    assign b_neg        = is_signed_op & bus.src_b[WIDTH-1];
    assign a_mag        = a_neg ? -bus.src_a : bus.src_a;
    assign b_mag        = b_neg ? -bus.src_b : bus.src_b;

    // Shift-add: the multiplicand is gated by the current multiplier lsb
    genvar gi;
    generate
        for (gi = 0; gi < 2*WIDTH; gi++) begin : g_pp
            assign pp_gated[gi] = mcand_reg[gi] & opb_reg[0];
        end
    endgenerate
    assign mul_step = acc_reg + pp_gated;

    // Restoring divide on {remainder, quotient}; quotient bits enter at the lsb
    assign rem_shift = {acc_reg[2*WIDTH-1:WIDTH], acc_reg[WIDTH-1]};
    assign rem_diff  = rem_shift - {1'b0, opb_reg};
    assign q_bit     = ~rem_diff[WIDTH];
    assign div_step  = {(q_bit ? rem_diff[WIDTH-1:0] : rem_shift[WIDTH-1:0]),
                        acc_reg[WIDTH-2:0], q_bit};

    assign quo_mag = acc_reg[WIDTH-1:0];
    assign rem_mag = acc_reg[2*WIDTH-1:WIDTH];

`ifdef ALU_MDU_EARLY_OUT_EN
    // Bit 0 is consumed at accept, so the unit can leave as soon as the bits above are clear
    assign early_accept = ~is_div_op && (b_mag[WIDTH-1:1] == '0);
    assign early_iter   = ~is_div_reg && (opb_reg[WIDTH-1:1] == '0);
`else
    assign early_accept = 1'b0;
    assign early_iter   = 1'b0;
`endif

    always_comb begin
        alu_out = '0;
        case (bus.aluop)
            OP_ADD:  alu_out = bus.src_a + bus.src_b;
            OP_SUB:  alu_out = bus.src_a - bus.src_b;
            OP_SLT:  alu_out = {{(WIDTH-1){1'b0}}, ($signed(bus.src_a) < $signed(bus.src_b))};
            OP_AND:  alu_out = bus.src_a & bus.src_b;
            OP_NOR:  alu_out = ~(bus.src_a | bus.src_b);
            OP_OR:   alu_out = bus.src_a | bus.src_b;
            OP_XOR:  alu_out = bus.src_a ^ bus.src_b;
            OP_SLL:  alu_out = bus.src_b << bus.shamt;
            OP_SRL:  alu_out = bus.src_b >> bus.shamt;
            OP_SLTU: alu_out = {{(WIDTH-1){1'b0}}, (bus.src_a < bus.src_b)};
            OP_SLLV: alu_out = bus.src_b << bus.src_a[SHW-1:0];
            OP_SRLV: alu_out = bus.src_b >> bus.src_a[SHW-1:0];
            OP_SRAV: alu_out = $unsigned($signed(bus.src_b) >>> bus.src_a[SHW-1:0]);
            OP_SRA:  alu_out = $unsigned($signed(bus.src_b) >>> bus.shamt);
            OP_LUI:  alu_out = {bus.src_b[WIDTH/2-1:0], {(WIDTH/2){1'b0}}};
            OP_MFHI: alu_out = hi_reg;
            OP_MFLO: alu_out = lo_reg;
            default: alu_out = '0;
        endcase
    end

    always_comb begin
        state_next     = state_reg;
        cnt_next       = cnt_reg;
        acc_next       = acc_reg;
        mcand_next     = mcand_reg;
        opb_next       = opb_reg;
        is_div_next    = is_div_reg;
        neg_res_next   = neg_res_reg;
        neg_rem_next   = neg_rem_reg;
        div0_next      = div0_reg;
        result_next    = result_reg;
        zero_next      = zero_reg;
        hi_next        = hi_reg;
        lo_next        = lo_reg;
        res_valid_next = 1'b0;

        case (state_reg)
            IDLE: begin
                if (bus.op_valid) begin
                    if (is_mc_op) begin
                        cnt_next     = '0;
                        is_div_next  = is_div_op;
                        neg_res_next = a_neg ^ b_neg;
                        neg_rem_next = a_neg;
                        div0_next    = (bus.src_b == '0);
                        if (is_div_op) begin
                            acc_next   = {{WIDTH{1'b0}}, a_mag};
                            mcand_next = '0;
                            opb_next   = b_mag;
                            state_next = ITER;
                        end else begin
                            acc_next   = b_mag[0] ? {{WIDTH{1'b0}}, a_mag} : '0;
                            mcand_next = {{(WIDTH-1){1'b0}}, a_mag, 1'b0};
                            opb_next   = b_mag >> 1;
                            state_next = early_accept ? FIX : ITER;
                        end
                    end else begin
                        result_next    = alu_out;
                        zero_next      = (alu_out == '0);
                        res_valid_next = 1'b1;
                    end
                end
            end
            ITER: begin
                cnt_next = cnt_reg + 1'b1;
                if (is_div_reg) begin
                    acc_next = div_step;
                end else begin
                    acc_next   = mul_step;
                    mcand_next = mcand_reg << 1;
                    opb_next   = opb_reg >> 1;
                end
                if ((cnt_reg == '1) || early_iter) begin
                    state_next = FIX;
                end
            end
            FIX: begin
                // A zero divisor leaves the dividend as remainder, so only the quotient is forced
                if (is_div_reg) begin
                    lo_next = div0_reg ? '1 : (neg_res_reg ? -quo_mag : quo_mag);
                    hi_next = neg_rem_reg ? -rem_mag : rem_mag;
                end else begin
                    {hi_next, lo_next} = neg_res_reg ? -acc_reg : acc_reg;
                end
                result_next    = lo_next;
                zero_next      = (lo_next == '0);
                res_valid_next = 1'b1;
                state_next     = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            cnt_reg       <= '0;
            acc_reg       <= '0;
            mcand_reg     <= '0;
            opb_reg       <= '0;
            is_div_reg    <= 1'b0;
            neg_res_reg   <= 1'b0;
            neg_rem_reg   <= 1'b0;
            div0_reg      <= 1'b0;
            result_reg    <= '0;
            zero_reg      <= 1'b1;
            hi_reg        <= '0;
            lo_reg        <= '0;
            res_valid_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            cnt_reg       <= cnt_next;
            acc_reg       <= acc_next;
            mcand_reg     <= mcand_next;
            opb_reg       <= opb_next;
            is_div_reg    <= is_div_next;
            neg_res_reg   <= neg_res_next;
            neg_rem_reg   <= neg_rem_next;
            div0_reg      <= div0_next;
            result_reg    <= result_next;
            zero_reg      <= zero_next;
            hi_reg        <= hi_next;
            lo_reg        <= lo_next;
            res_valid_reg <= res_valid_next;
        end
    end

    assign bus.op_ready  = (state_reg == IDLE);
    assign bus.busy      = (state_reg != IDLE);
    assign bus.res_valid = res_valid_reg;
    assign bus.result    = result_reg;
    assign bus.zero      = zero_reg;
    assign bus.hi        = hi_reg;
    assign bus.lo        = lo_reg;
endmodule

// File: tb/tb_alu_mdu.sv
// Scoreboard bench for alu_mdu: driver issues ops and queues model results, a monitor checks each res_valid.
// Latency expectations follow ALU_MDU_EARLY_OUT_EN when the bench is built with it.
module tb_alu_mdu;
    localparam int W = 32;
    localparam int S = 5;

    localparam logic [4:0] OP_ADD   = 5'b00000;
    localparam logic [4:0] OP_SUB   = 5'b00001;
    localparam logic [4:0] OP_SLT   = 5'b00010;
    localparam logic [4:0] OP_AND   = 5'b00011;
    localparam logic [4:0] OP_NOR   = 5'b00100;
    localparam logic [4:0] OP_OR    = 5'b00101;
    localparam logic [4:0] OP_XOR   = 5'b00110;
    localparam logic [4:0] OP_SLL   = 5'b00111;
    localparam logic [4:0] OP_SRL   = 5'b01000;
    localparam logic [4:0] OP_SLTU  = 5'b01001;
    localparam logic [4:0] OP_SLLV  = 5'b01100;
    localparam logic [4:0] OP_SRA   = 5'b01101;
    localparam logic [4:0] OP_SRAV  = 5'b01110;
    localparam logic [4:0] OP_SRLV  = 5'b01111;
    localparam logic [4:0] OP_LUI   = 5'b10000;
    localparam logic [4:0] OP_MULT  = 5'b10001;
    localparam logic [4:0] OP_MULTU = 5'b10010;
    localparam logic [4:0] OP_DIV   = 5'b10011;
    localparam logic [4:0] OP_DIVU  = 5'b10100;
    localparam logic [4:0] OP_MFHI  = 5'b10101;
    localparam logic [4:0] OP_MFLO  = 5'b10110;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    alu_mdu_if #(.WIDTH(W), .SHW(S)) bus ();
    alu_mdu #(.WIDTH(W), .SHW(S)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    typedef struct {
        logic [4:0]  op;
        logic [31:0] res;
        logic [31:0] hi;
        logic [31:0] lo;
        longint      due;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] m_hi = '0;
    logic [31:0] m_lo = '0;
    int          checks = 0;
    int          failures = 0;
    longint      cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got 0x%0h required 0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Reference behaviour straight from the op definitions; HI/LO tracked as plain state
    task automatic model(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] sh, output logic [31:0] res, output int lat);
        longint p;
        int q, r;
`ifdef ALU_MDU_EARLY_OUT_EN
        logic [31:0] mag;
        int bits;
`endif
        res = '0;
        lat = 1;
        case (op)
            OP_ADD:  res = a + b;
            OP_SUB:  res = a - b;
            OP_SLT:  res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            OP_AND:  res = a & b;
            OP_NOR:  res = ~(a | b);
            OP_OR:   res = a | b;
            OP_XOR:  res = a ^ b;
            OP_SLL:  res = b << sh;
            OP_SRL:  res = b >> sh;
            OP_SLTU: res = (a < b) ? 32'd1 : 32'd0;
            OP_SLLV: res = b << a[4:0];
            OP_SRLV: res = b >> a[4:0];
            OP_SRAV: res = $signed(b) >>> a[4:0];
            OP_SRA:  res = $signed(b) >>> sh;
            OP_LUI:  res = {b[15:0], 16'h0000};
            OP_MFHI: res = m_hi;
            OP_MFLO: res = m_lo;
            OP_MULT, OP_MULTU: begin
                if (op == OP_MULT) p = longint'($signed(a)) * longint'($signed(b));
                else               p = longint'({32'h0, a}) * longint'({32'h0, b});
                {m_hi, m_lo} = p;
                res = m_lo;
                lat = W + 2;
`ifdef ALU_MDU_EARLY_OUT_EN
                mag = (op == OP_MULT && b[31]) ? -b : b;
                bits = 0;
                for (int i = 0; i < 32; i++) if (mag[i]) bits = i + 1;
                lat = ((bits < 1) ? 1 : bits) + 1;
`endif
            end
            OP_DIV, OP_DIVU: begin
                if (b == 0) begin
                    m_lo = 32'hFFFF_FFFF;
                    m_hi = a;
                end else if (op == OP_DIV && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                    m_lo = 32'h8000_0000;
                    m_hi = 32'h0;
                end else if (op == OP_DIV) begin
                    q = int'(a) / int'(b);
                    r = int'(a) % int'(b);
                    m_lo = q;
                    m_hi = r;
                end else begin
                    m_lo = a / b;
                    m_hi = a % b;
                end
                res = m_lo;
                lat = W + 2;
            end
            default: res = '0;
        endcase
    endtask

    task automatic issue(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] sh);
        exp_t e;
        logic [31:0] res;
        int lat;
        int budget;
        bus.op_valid = 1'b1;
        bus.aluop    = op;
        bus.src_a    = a;
        bus.src_b    = b;
        bus.shamt    = sh;
        budget = 0;
        while (!bus.op_ready && budget < 100) begin
            @(posedge clk); #1;
            budget++;
        end
        if (!bus.op_ready) begin
            checks++;
            failures++;
            $display("FAIL ready_timeout: op_ready=0 after 100 cycles, required 1");
            bus.op_valid = 1'b0;
            return;
        end
        model(op, a, b, sh, res, lat);
        @(posedge clk); #1;
        e.op  = op;
        e.res = res;
        e.hi  = m_hi;
        e.lo  = m_lo;
        e.due = cyc + lat - 1;
        sb.push_back(e);
        bus.op_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        bus.op_valid = 1'b0;
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic drain();
        int budget;
        budget = 0;
        while (sb.size() != 0 && budget < 200) begin
            @(posedge clk); #1;
            budget++;
        end
        chk("drain_pending", sb.size(), 0);
    endtask

    function automatic logic [31:0] rnd_val();
        case ($urandom_range(0, 7))
            0: return 32'h0;
            1: return 32'h1;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'($urandom_range(0, 15));
            5: return -32'($urandom_range(1, 15));
            default: return $urandom;
        endcase
    endfunction

    // Monitor: every res_valid must match the oldest queued expectation, on its due cycle
    always @(negedge clk) begin : mon
        exp_t e;
        if (rst_n && bus.res_valid) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_res_valid: res_valid=1 at cycle %0d, required 0", cyc);
            end else begin
                e = sb.pop_front();
                $display("txn cyc=%0d op=%b result=%h zero=%b hi=%h lo=%h",
                         cyc, e.op, bus.result, bus.zero, bus.hi, bus.lo);
                chk("result", bus.result, e.res);
                chk("zero", bus.zero, (e.res == 0));
                chk("hi", bus.hi, e.hi);
                chk("lo", bus.lo, e.lo);
                chk("latency_cycle", cyc, e.due);
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: time limit reached with %0d pending", sb.size());
        $fatal(1, "watchdog");
    end

    initial begin
        logic [4:0]  rop;
        logic [31:0] ra, rb;
        logic [4:0]  rsh;

        bus.op_valid = 1'b0;
        bus.aluop    = '0;
        bus.src_a    = '0;
        bus.src_b    = '0;
        bus.shamt    = '0;
        repeat (3) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        #1;
        chk("rst_result", bus.result, 0);
        chk("rst_zero", bus.zero, 1);
        chk("rst_hi", bus.hi, 0);
        chk("rst_lo", bus.lo, 0);
        chk("rst_res_valid", bus.res_valid, 0);
        chk("rst_op_ready", bus.op_ready, 1);
        chk("rst_busy", bus.busy, 0);
        @(posedge clk); #1;

        // Back-to-back single-cycle ops
        issue(OP_ADD, 32'd7, 32'd5, 5'd0);
        issue(OP_SLT, 32'hFFFF_FFFF, 32'd1, 5'd0);
        issue(OP_SLTU, 32'hFFFF_FFFF, 32'd1, 5'd0);
        issue(OP_SRA, 32'd0, 32'h8000_0000, 5'd4);
        issue(OP_LUI, 32'd0, 32'h0000_ABCD, 5'd0);
        issue(5'b11111, 32'd3, 32'd4, 5'd1);
        idle(2);

        issue(OP_MULT, 32'hFFFF_FFFD, 32'd7, 5'd0);
        chk("busy_during_mult", bus.busy, 1);
        chk("ready_during_mult", bus.op_ready, 0);
        issue(OP_MFLO, 32'd0, 32'd0, 5'd0);
        issue(OP_MFHI, 32'd0, 32'd0, 5'd0);
        drain();

        issue(OP_DIV, 32'hFFFF_FFF9, 32'd2, 5'd0);
        issue(OP_DIVU, 32'd7, 32'd0, 5'd0);
        issue(OP_DIV, 32'hFFFF_FFF9, 32'd0, 5'd0);

        // Overflow divide with a stray add request and operand churn while busy
        issue(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 5'd0);
        idle(3);
        bus.op_valid = 1'b1;
        bus.aluop    = OP_ADD;
        bus.src_a    = $urandom;
        bus.src_b    = $urandom;
        @(posedge clk); #1;
        bus.op_valid = 1'b0;
        bus.src_a    = $urandom;
        bus.src_b    = $urandom;
        chk("busy_after_stray", bus.busy, 1);
        drain();

        issue(OP_MULTU, 32'd9, 32'd5, 5'd0);
        issue(OP_MULT, 32'h8000_0000, 32'h8000_0000, 5'd0);
        issue(OP_MULTU, 32'hFFFF_FFFF, 32'd1, 5'd0);
        issue(OP_MFHI, 32'd0, 32'd0, 5'd0);
        drain();

        // Reset in the middle of a multiply
        issue(OP_MULT, 32'd123, 32'h8765_4321, 5'd0);
        repeat (8) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        sb.delete();
        m_hi = '0;
        m_lo = '0;
        chk("midrst_result", bus.result, 0);
        chk("midrst_hi", bus.hi, 0);
        chk("midrst_lo", bus.lo, 0);
        chk("midrst_zero", bus.zero, 1);
        chk("midrst_res_valid", bus.res_valid, 0);
        chk("midrst_op_ready", bus.op_ready, 1);
        chk("midrst_busy", bus.busy, 0);
        @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        idle(40);
        chk("postrst_hi", bus.hi, 0);
        chk("postrst_op_ready", bus.op_ready, 1);
        issue(OP_MFHI, 32'd0, 32'd0, 5'd0);
        drain();

        // Randomized traffic across every opcode, including unused ones
        for (int n = 0; n < 160; n++) begin
            rop = 5'($urandom_range(0, 31));
            ra  = rnd_val();
            rb  = rnd_val();
            rsh = 5'($urandom);
            issue(rop, ra, rb, rsh);
            if ($urandom_range(0, 3) == 0) idle(1 + $urandom_range(0, 1));
        end
        drain();
        idle(4);
        chk("scoreboard_empty", sb.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
